// File: rtl/axis_ram_reader_seg_if.sv
// Bus bundle for axis_ram_reader_seg: AXI3 read address/data channels and
// the AXI4-Stream output. The optional m_axis_tlast member exists only when
// AXIS_RAM_READER_TLAST_EN is defined.
interface axis_ram_reader_seg_if #(
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64
);
  // AXI3 read address channel
  logic [AXI_ID_WIDTH-1:0]     m_axi_arid;
  logic [3:0]                  m_axi_arlen;
  logic [2:0]                  m_axi_arsize;
  logic [1:0]                  m_axi_arburst;
  logic [3:0]                  m_axi_arcache;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr;
  logic                        m_axi_arvalid;
  logic                        m_axi_arready;
  // AXI3 read data channel
  logic [AXI_ID_WIDTH-1:0]     m_axi_rid;
  logic                        m_axi_rlast;
  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata;
  logic                        m_axi_rvalid;
  logic                        m_axi_rready;
  // AXI4-Stream output
  logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
`ifdef AXIS_RAM_READER_TLAST_EN
  logic                        m_axis_tlast;
`endif

  modport master (
    output m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rlast, m_axi_rdata, m_axi_rvalid,
    output m_axi_rready,
`ifdef AXIS_RAM_READER_TLAST_EN
    output m_axis_tlast,
`endif
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rlast, m_axi_rdata, m_axi_rvalid,
    input  m_axi_rready,
`ifdef AXIS_RAM_READER_TLAST_EN
    input  m_axis_tlast,
`endif
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_ram_reader_seg.sv
// axis_ram_reader_seg: multi-burst AXI3 read master streaming a segmented
// circular RAM buffer into an AXI4-Stream sink. Bursts are issued only when
// the output FIFO is guaranteed to hold every outstanding burst, so R data is
// always accepted (rready tied high) and the FIFO can never overflow.
// The AXIS width must divide the R data width; narrower words are emitted
// least-significant slice first.
// Optional feature macro: AXIS_RAM_READER_TLAST_EN adds m_axis_tlast, marking
// the final beat of every pass (requires AXIS_TDATA_WIDTH == AXI_DATA_WIDTH).
module axis_ram_reader_seg #(
  parameter int ADDR_WIDTH       = 16,
  parameter int SEG_BITS         = 2,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int BURST_LEN        = 16,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int FIFO_WRITE_DEPTH = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] min_addr,
  input  logic [ADDR_WIDTH-1:0]     cfg_data,
  input  logic                      cfg_enable,
  input  logic                      cfg_oneshot,
  output logic [ADDR_WIDTH-1:0]     sts_data,
  output logic                      sts_busy,
  output logic                      sts_done,
  axis_ram_reader_seg_if.master     bus
);

  localparam int BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam int ADDR_SHIFT = $clog2(BURST_LEN) + BEAT_SHIFT;
  localparam int FIFO_AW    = $clog2(FIFO_WRITE_DEPTH);
  localparam int CNT_W      = FIFO_AW + 1;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int RATIO      = AXI_DATA_WIDTH / AXIS_TDATA_WIDTH;
  localparam int SUB_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
`ifdef AXIS_RAM_READER_TLAST_EN
  localparam int FIFO_DW    = AXI_DATA_WIDTH + 1;
  localparam int TAG_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
`else
  localparam int FIFO_DW    = AXI_DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_r;
  logic                      arvalid_r;
  logic [AXI_ADDR_WIDTH-1:0] araddr_r;
  logic [ADDR_WIDTH-1:0]     idx_r;
  logic [ADDR_WIDTH-1:0]     limit_r;
  logic                      busy_r;
  logic                      done_r;
  logic [OUT_W-1:0]          outstanding_r;

  logic [FIFO_DW-1:0]        mem_r [FIFO_WRITE_DEPTH];
  logic [FIFO_AW-1:0]        wr_ptr_r;
  logic [FIFO_AW-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]          count_r;
  logic [CNT_W-1:0]          count_next_s;
  logic [SUB_W-1:0]          sub_r;
  logic                      tvalid_r;

  logic                      ar_hs_s;
  logic                      r_last_s;
  logic                      pass_end_s;
  logic                      credit_ok_s;
  logic [ADDR_WIDTH-1:0]     seg_base_s;
  logic [CNT_W-1:0]          free_s;
  logic [CNT_W-1:0]          need_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      last_sub_s;
  logic [FIFO_DW-1:0]        fifo_wdata_s;
  logic [FIFO_DW-1:0]        head_s;

  // Fixed AR attributes: single ID, full bursts, native beat size, INCR, cacheable.
  assign bus.m_axi_arid    = {AXI_ID_WIDTH{1'b0}};
  assign bus.m_axi_arlen   = 4'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'(BEAT_SHIFT);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arcache = 4'b0110;
  assign bus.m_axi_rready  = 1'b1;
  assign bus.m_axi_arvalid = arvalid_r;
  assign bus.m_axi_araddr  = araddr_r;

  assign sts_data = idx_r;
  assign sts_busy = busy_r;
  assign sts_done = done_r;

  assign ar_hs_s    = arvalid_r & bus.m_axi_arready;
  assign r_last_s   = bus.m_axi_rvalid & bus.m_axi_rlast;
  assign pass_end_s = (idx_r >= limit_r);
  assign seg_base_s = {cfg_data[ADDR_WIDTH-1 -: SEG_BITS], {(ADDR_WIDTH-SEG_BITS){1'b0}}};

  // Credit: every issued-but-unfinished burst plus the candidate must fit in
  // the free FIFO space, counted in whole bursts.
  assign free_s      = CNT_W'(FIFO_WRITE_DEPTH) - count_r;
  assign need_s      = CNT_W'((32'(outstanding_r) + 32'd1) * 32'(BURST_LEN));
  assign credit_ok_s = (32'(outstanding_r) < 32'(MAX_OUTSTANDING)) && (free_s >= need_s);

  // Control FSM: burst index walk, pass boundaries, AR issue and drain/done.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      arvalid_r <= 1'b0;
      araddr_r  <= {AXI_ADDR_WIDTH{1'b0}};
      idx_r     <= {ADDR_WIDTH{1'b0}};
      limit_r   <= {ADDR_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_enable) begin
            limit_r <= cfg_data;
            idx_r   <= seg_base_s;
            busy_r  <= 1'b1;
            state_r <= ST_ISSUE;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (arvalid_r) begin
            // Address and index stay frozen until the slave accepts.
            if (bus.m_axi_arready) begin
              arvalid_r <= 1'b0;
              if (pass_end_s) begin
                // New configuration only takes effect at a pass boundary.
                idx_r   <= seg_base_s;
                limit_r <= cfg_data;
              end else begin
                idx_r   <= idx_r + ADDR_WIDTH'(1'b1);
              end
              if ((pass_end_s && cfg_oneshot) || !cfg_enable) begin
                state_r <= ST_DRAIN;
              end
            end
          end else if (!cfg_enable) begin
            state_r <= ST_DRAIN;
          end else if (credit_ok_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= min_addr + (AXI_ADDR_WIDTH'(idx_r) << ADDR_SHIFT);
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == {OUT_W{1'b0}}) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding burst counter: +1 per AR handshake, -1 per final R beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      outstanding_r <= {OUT_W{1'b0}};
    end else begin
      case ({ar_hs_s, r_last_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_W'(1'b1);
        2'b01:   outstanding_r <= outstanding_r - OUT_W'(1'b1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

`ifdef AXIS_RAM_READER_TLAST_EN
  logic             tag_mem_r [MAX_OUTSTANDING];
  logic [TAG_W-1:0] tag_wr_r;
  logic [TAG_W-1:0] tag_rd_r;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] ptr);
    return (32'(ptr) == MAX_OUTSTANDING - 1) ? {TAG_W{1'b0}} : ptr + TAG_W'(1'b1);
  endfunction

  // Pass-end tag per issued burst, consumed in order as each burst finishes.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tag_wr_r <= {TAG_W{1'b0}};
      tag_rd_r <= {TAG_W{1'b0}};
    end else begin
      if (ar_hs_s) begin
        tag_mem_r[tag_wr_r] <= pass_end_s;
        tag_wr_r            <= tag_next(tag_wr_r);
      end
      if (r_last_s) begin
        tag_rd_r <= tag_next(tag_rd_r);
      end
    end
  end

  assign fifo_wdata_s     = {bus.m_axi_rlast & tag_mem_r[tag_rd_r], bus.m_axi_rdata};
  assign bus.m_axis_tlast = tvalid_r & head_s[FIFO_DW-1] & last_sub_s;
`else
  assign fifo_wdata_s = bus.m_axi_rdata;
`endif

  assign push_s     = bus.m_axi_rvalid;
  assign last_sub_s = (32'(sub_r) == RATIO - 1);
  assign pop_s      = tvalid_r & bus.m_axis_tready & last_sub_s;
  assign head_s     = mem_r[rd_ptr_r];

  assign bus.m_axis_tvalid = tvalid_r;
  assign bus.m_axis_tdata  = AXIS_TDATA_WIDTH'(head_s[AXI_DATA_WIDTH-1:0] >> (AXIS_TDATA_WIDTH * 32'(sub_r)));

  // Next FIFO occupancy from simultaneous push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage write port; contents need no reset since pointers are flushed.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fifo_wdata_s;
    end
  end

  // FIFO pointers, occupancy and output-slice sequencing (first-word fall-through).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      sub_r    <= {SUB_W{1'b0}};
      tvalid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
      end
      if (tvalid_r && bus.m_axis_tready) begin
        if (last_sub_s) begin
          rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
          sub_r    <= {SUB_W{1'b0}};
        end else begin
          sub_r    <= sub_r + SUB_W'(1'b1);
        end
      end
      count_r  <= count_next_s;
      tvalid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_axis_ram_reader_seg.sv
// Self-checking bench for axis_ram_reader_seg: table of one-shot passes plus
// hand-written loop/stall/credit/drain sequences. A bench-side AXI slave
// supplies address-derived data and queues the expected AXIS beats.
module tb_axis_ram_reader_seg;
  localparam int AW = 16, DW = 64, BL = 16, MAXO = 4, DEPTH = 64;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] min_addr;
  logic [15:0] cfg_data;
  logic        cfg_enable, cfg_oneshot;
  logic [15:0] sts_data;
  logic        sts_busy, sts_done;

  axis_ram_reader_seg_if #(.AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32),
                           .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(DW)) bus ();

  axis_ram_reader_seg #(
    .ADDR_WIDTH(AW), .SEG_BITS(2), .AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(DW), .BURST_LEN(BL),
    .MAX_OUTSTANDING(MAXO), .FIFO_WRITE_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .min_addr(min_addr), .cfg_data(cfg_data),
    .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot), .sts_data(sts_data),
    .sts_busy(sts_busy), .sts_done(sts_done), .bus(bus)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [63:0] data; logic last; } beat_t;
  typedef struct packed { logic [31:0] addr; logic pend; } burst_t;
  typedef struct { logic [15:0] cfg; int n_ar; logic [15:0] sts_after; } vec_t;

  beat_t  exp_q[$];
  burst_t burst_q[$];
  int n_cmp = 0, n_bad = 0;
  int ar_cnt = 0, beat_cnt = 0, done_cnt = 0, m_out = 0, max_out = 0;
  int fill = 0, max_fill = 0, coincide = 0, beat_i = 0;
  logic ar_hold = 1'b0, rel_on_last = 1'b0, tready_en = 1'b1, seen_seg1 = 1'b0;
  logic [15:0] m_idx = 16'h0000, m_limit = 16'h0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bench-side AXI slave, AXIS sink and expected-AR model, all at negedge.
  initial begin : bus_model
    logic [31:0] a, ea;
    beat_t e;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    bus.m_axi_rdata = 64'h0; bus.m_axi_rid = 6'h0; bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        continue;
      end
      // R beat for the oldest accepted burst
      if (burst_q.size() != 0) begin
        a = burst_q[0].addr + 32'(beat_i * 8);
        bus.m_axi_rdata  = {a ^ 32'hDEADBEEF, a};
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = (beat_i == BL - 1);
        exp_q.push_back('{data: {a ^ 32'hDEADBEEF, a}, last: (beat_i == BL - 1) && burst_q[0].pend});
        fill++;
        if (beat_i == BL - 1) begin
          burst_q.delete(0); beat_i = 0; m_out--;
        end else begin
          beat_i++;
        end
      end else begin
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
      end
      bus.m_axi_arready = !ar_hold || (rel_on_last && bus.m_axi_rvalid && bus.m_axi_rlast);
      bus.m_axis_tready = tready_en;
      if (sts_done) done_cnt++;
      // AXIS output compared against the scoreboard
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("axis_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", bus.m_axis_tdata, e.data);
`ifdef AXIS_RAM_READER_TLAST_EN
          check("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
`endif
        end
        beat_cnt++; fill--;
      end
      // AR handshake about to complete on the next rising edge
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        if (bus.m_axi_rvalid && bus.m_axi_rlast) coincide++;
        ea = min_addr + ({16'h0000, m_idx} << 7);
        check("araddr", bus.m_axi_araddr, ea);
        if (m_idx[15:14] == 2'b01) seen_seg1 = 1'b1;
        burst_q.push_back('{addr: ea, pend: (m_idx >= m_limit)});
        if (m_idx >= m_limit) begin
          m_idx = {cfg_data[15:14], 14'h0000}; m_limit = cfg_data;
        end else begin
          m_idx = m_idx + 16'd1;
        end
        ar_cnt++; m_out++;
      end
      if (m_out > max_out) max_out = m_out;
      if (fill > max_fill) max_fill = fill;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic start(input logic [15:0] cfg, input logic os);
    cfg_data = cfg; cfg_oneshot = os;
    m_idx = {cfg[15:14], 14'h0000}; m_limit = cfg;
    cfg_enable = 1'b1;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (sts_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ar(input int target, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (ar_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain_check(input string name);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge aclk);
    cyc(2);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : main
    vec_t vecs[5];
    logic ok, stable;
    logic [31:0] sa;
    logic [15:0] si;
    int ar0, b0, d0, a1, c0;

    vecs[0] = '{cfg: 16'h0003, n_ar: 4, sts_after: 16'h0000};
    vecs[1] = '{cfg: 16'h8002, n_ar: 3, sts_after: 16'h8000};
    vecs[2] = '{cfg: 16'h4000, n_ar: 1, sts_after: 16'h4000};
    vecs[3] = '{cfg: 16'h0000, n_ar: 1, sts_after: 16'h0000};
    vecs[4] = '{cfg: 16'hC001, n_ar: 2, sts_after: 16'hC000};

    min_addr = 32'h1000_0000; cfg_data = 16'h0000;
    cfg_enable = 1'b0; cfg_oneshot = 1'b0;
    cyc(5); aresetn = 1'b1; cyc(1);

    // reset state and constant AR attributes
    check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    check("rst_tvalid",  64'(bus.m_axis_tvalid), 64'd0);
    check("rst_busy",    64'(sts_busy), 64'd0);
    check("rst_done",    64'(sts_done), 64'd0);
    check("rst_sts_data", 64'(sts_data), 64'd0);
    check("rready",      64'(bus.m_axi_rready), 64'd1);
    check("arlen",       64'(bus.m_axi_arlen), 64'd15);
    check("arsize",      64'(bus.m_axi_arsize), 64'd3);
    check("arburst",     64'(bus.m_axi_arburst), 64'd1);
    check("arcache",     64'(bus.m_axi_arcache), 64'd6);
    check("arid",        64'(bus.m_axi_arid), 64'd0);

    // table: one-shot passes
    for (int v = 0; v < 5; v++) begin
      ar0 = ar_cnt; b0 = beat_cnt; d0 = done_cnt;
      start(vecs[v].cfg, 1'b1);
      check("busy_running", 64'(sts_busy), 64'd0);
      cyc(1);
      check("busy_after_enable", 64'(sts_busy), 64'd1);
      wait_done(2000, ok);
      check("oneshot_done_seen", 64'(ok), 64'd1);
      cfg_enable = 1'b0;
      drain_check("oneshot_scoreboard_empty");
      check("oneshot_ar_count", 64'(ar_cnt - ar0), 64'(vecs[v].n_ar));
      check("oneshot_beats", 64'(beat_cnt - b0), 64'(vecs[v].n_ar * BL));
      check("oneshot_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("oneshot_busy_idle", 64'(sts_busy), 64'd0);
      check("oneshot_sts_data", 64'(sts_data), 64'(vecs[v].sts_after));
    end

    // loop mode on segment 2, wrapping several passes
    ar0 = ar_cnt;
    start(16'h8002, 1'b0);
    wait_ar(ar0 + 7, 3000, ok);
    check("loop_progress", 64'(ok), 64'd1);

    // arready stall: AR must hold steady without duplicates
    ar_hold = 1'b1; cyc(2);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      ok = bus.m_axi_arvalid;
    end
    check("stall_arvalid_seen", 64'(ok), 64'd1);
    sa = bus.m_axi_araddr; si = sts_data; a1 = ar_cnt; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!bus.m_axi_arvalid || bus.m_axi_araddr !== sa || sts_data !== si) stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_no_ar", 64'(ar_cnt - a1), 64'd0);

    // mid-pass reconfiguration; release arready exactly on an rlast beat
    cfg_data = 16'h4001; seen_seg1 = 1'b0;
    c0 = coincide; rel_on_last = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      ok = (coincide > c0);
    end
    check("rlast_coincide", 64'(ok), 64'd1);
    rel_on_last = 1'b0; ar_hold = 1'b0;
    wait_ar(ar_cnt + 8, 3000, ok);
    check("loop_after_reconfig", 64'(ok), 64'd1);
    check("new_cfg_used", 64'(seen_seg1), 64'd1);

    // disable mid-pass: drain, done only after the last rlast
    cfg_enable = 1'b0;
    wait_done(2000, ok);
    check("disable_done_seen", 64'(ok), 64'd1);
    check("disable_out_zero", 64'(m_out), 64'd0);
    drain_check("disable_scoreboard_empty");
    check("disable_busy_idle", 64'(sts_busy), 64'd0);

    // backpressure: FIFO credit stops AR issue, resumes with tready
    tready_en = 1'b0; cyc(1);
    ar0 = ar_cnt; max_out = 0; max_fill = 0;
    start(16'h0007, 1'b0);
    cyc(300);
    check("credit_ar_count", 64'(ar_cnt - ar0), 64'(DEPTH / BL));
    check("credit_fill", 64'(fill), 64'(DEPTH));
    check("credit_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    check("credit_arvalid_low", 64'(bus.m_axi_arvalid), 64'd0);
    check("max_outstanding", 64'(max_out <= MAXO), 64'd1);
    check("max_fill", 64'(max_fill <= DEPTH), 64'd1);
    tready_en = 1'b1;
    wait_ar(ar0 + 10, 3000, ok);
    check("credit_resume", 64'(ok), 64'd1);
    cfg_enable = 1'b0;
    wait_done(2000, ok);
    check("final_done_seen", 64'(ok), 64'd1);
    check("final_out_zero", 64'(m_out), 64'd0);
    drain_check("final_scoreboard_empty");
    check("final_busy_idle", 64'(sts_busy), 64'd0);
    check("final_tvalid_idle", 64'(bus.m_axis_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
